// File: rtl/hand_score_accum.sv
// hand_score_accum: multi-hand Baccarat score accumulator.
// Cards arrive one per cycle over a valid/ready handshake and are tagged
// with a hand index. Each hand keeps a running score (sum mod 10) and a
// card count. The block also flags full hands and raises a sticky
// protocol-error flag.
// Optional feature: define NATURAL_DETECT_EN to add the registered
// per-hand 'natural' output. It flags a hand whose score is 8 or 9 after
// its 2nd card.
module hand_score_accum #(
  parameter int NUM_HANDS = 2,
  parameter int MAX_CARDS = 3,
  parameter int HW        = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  parameter int CW        = $clog2(MAX_CARDS + 1)
) (
  input  logic                    slow_clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load_valid,
  input  logic [HW-1:0]           load_hand,
  input  logic [3:0]              load_card,
  output logic                    load_ready,
  output logic [4*NUM_HANDS-1:0]  score,
  output logic [CW*NUM_HANDS-1:0] count,
  output logic [NUM_HANDS-1:0]    full,
  output logic                    err
`ifdef NATURAL_DETECT_EN
  ,
  output logic [NUM_HANDS-1:0]    natural
`endif
);

  // Per-hand state.
  logic [3:0]    r_score [NUM_HANDS];
  logic [CW-1:0] r_count [NUM_HANDS];
  logic          r_err;

  // Datapath for the addressed hand. Only one hand updates per cycle, so a
  // single adder is shared.
  logic          w_hand_ok;
  logic [3:0]    w_sel_score;
  logic [CW-1:0] w_sel_count;
  logic          w_sel_full;
  logic          w_accept;
  logic          w_illegal_card;
  logic [3:0]    w_card_val;
  logic [4:0]    w_sum;
  logic [3:0]    w_new_score;
  logic          w_set_err;

  // Hand index range check. When NUM_HANDS fills the index width, every
  // index is legal and the compare folds away.
  generate
    if (NUM_HANDS == (1 << HW)) begin : g_hand_all_legal
      assign w_hand_ok = 1'b1;
    end else begin : g_hand_range
      assign w_hand_ok = ({{(32-HW){1'b0}}, load_hand} < 32'(NUM_HANDS));
    end
  endgenerate

  // Select the addressed hand's registered score and count.
  // NOTE: defaults are assigned before the loop, so no path through this block leaves a latch.
  always_comb begin
    w_sel_score = '0;
    w_sel_count = '0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (load_hand == HW'(h)) begin
        w_sel_score = r_score[h];
        w_sel_count = r_count[h];
      end
    end
  end

  assign w_sel_full = (w_sel_count == CW'(MAX_CARDS));
  assign load_ready = !clear && w_hand_ok && !w_sel_full;
  assign w_accept   = load_valid && load_ready;

  // Face cards, tens and illegal codes are all worth zero.
  assign w_card_val     = (load_card >= 4'd1 && load_card <= 4'd9) ? load_card : 4'd0;
  assign w_illegal_card = (load_card == 4'd0) || (load_card >= 4'd14);

  // Mod-10 add. The sum is at most 9 + 9 = 18, so one conditional subtract is enough.
  assign w_sum       = {1'b0, w_sel_score} + {1'b0, w_card_val};
  assign w_new_score = (w_sum >= 5'd10) ? 4'(w_sum - 5'd10) : w_sum[3:0];

  // A valid load that is out of range, targets a full hand, or carries an
  // illegal code flags an error. Clear overrides this in the register.
  assign w_set_err = load_valid && (!w_hand_ok || w_sel_full || w_illegal_card);

  // Hand registers: clear wins over load, and only the addressed hand updates.
  // NOTE: the per-hand arrays are small flop banks, not RAM, so they take the async reset directly.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        r_score[h] <= '0;
        r_count[h] <= '0;
      end
      r_err <= 1'b0;
    end else if (clear) begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        r_score[h] <= '0;
        r_count[h] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int h = 0; h < NUM_HANDS; h++) begin
          if (load_hand == HW'(h)) begin
            r_score[h] <= w_new_score;
            r_count[h] <= r_count[h] + CW'(1);
          end
        end
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef NATURAL_DETECT_EN
  logic [NUM_HANDS-1:0] r_natural;

  // Natural flag: set when the 2nd card lands on 8 or 9, held until clear/reset.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      r_natural <= '0;
    end else if (clear) begin
      r_natural <= '0;
    end else if (w_accept && (w_sel_count == CW'(1)) && (w_new_score >= 4'd8)) begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        if (load_hand == HW'(h)) begin
          r_natural[h] <= 1'b1;
        end
      end
    end
  end

  assign natural = r_natural;
`endif

  // Flatten per-hand state onto the packed output buses.
  always_comb begin
    score = '0;
    count = '0;
    full  = '0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      score[4*h +: 4]   = r_score[h];
      count[CW*h +: CW] = r_count[h];
      full[h]           = (r_count[h] == CW'(MAX_CARDS));
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_hand_score_accum.sv
// Testbench for hand_score_accum. It runs directed scenarios, then
// randomized traffic. All checks compare against a reference model. The
// model keeps, per hand, the raw sum of card values and the number of
// cards accepted.
module tb_hand_score_accum;

  localparam int NH  = 2;
  localparam int MAX = 3;
  localparam int HW  = 1;
  localparam int CW  = 2;

  logic              slow_clock = 1'b0;
  logic              reset      = 1'b1;
  logic              clear      = 1'b0;
  logic              load_valid = 1'b0;
  logic [HW-1:0]     load_hand  = '0;
  logic [3:0]        load_card  = '0;
  logic              load_ready;
  logic [4*NH-1:0]   score;
  logic [CW*NH-1:0]  count;
  logic [NH-1:0]     full;
  logic              err;
`ifdef NATURAL_DETECT_EN
  logic [NH-1:0]     natural;
`endif

  hand_score_accum #(.NUM_HANDS(NH), .MAX_CARDS(MAX)) dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .clear      (clear),
    .load_valid (load_valid),
    .load_hand  (load_hand),
    .load_card  (load_card),
    .load_ready (load_ready),
    .score      (score),
    .count      (count),
    .full       (full),
`ifdef NATURAL_DETECT_EN
    .natural    (natural),
`endif
    .err        (err)
  );

  always #5 slow_clock = ~slow_clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: raw value sum and card count per hand.
  int m_sum [NH];
  int m_cnt [NH];
  int m_nat [NH];
  int m_err;
  logic exp_ready;
  logic obs_ready;

  function automatic int sc(input int h);
    return int'(score[4*h +: 4]);
  endfunction

  function automatic int ct(input int h);
    return int'(count[CW*h +: CW]);
  endfunction

  task automatic model_reset();
    for (int h = 0; h < NH; h++) begin
      m_sum[h] = 0;
      m_cnt[h] = 0;
      m_nat[h] = 0;
    end
    m_err = 0;
  endtask

  // Drive one cycle of stimulus. Sample load_ready before the edge, apply
  // the edge to the model, then return #1 after the edge.
  task automatic apply(input logic v, input int h, input int c, input logic clr);
    int val;
    load_valid = v;
    load_hand  = HW'(h);
    load_card  = 4'(c);
    clear      = clr;
    #1;
    exp_ready = !clr && (h < NH) && (m_cnt[h] < MAX);
    obs_ready = load_ready;
    @(posedge slow_clock);
    if (clr) begin
      model_reset();
    end else if (v) begin
      if (!exp_ready) begin
        m_err = 1;
      end else begin
        val = (c >= 1 && c <= 9) ? c : 0;
        if (c == 0 || c >= 14) m_err = 1;
        m_sum[h] += val;
        m_cnt[h] += 1;
        if (m_cnt[h] == 2 && (m_sum[h] % 10) >= 8) m_nat[h] = 1;
      end
    end
    #1;
    load_valid = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_tests++;
    if (score !== '0 || count !== '0 || full !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: score=%h count=%h full=%b err=%b, want all 0", score, count, full, err);
    end
    @(negedge slow_clock);
    reset = 1'b0;
    @(posedge slow_clock);
    #1;
    model_reset();
  endtask

  task automatic test_plan_hand0();
    int cards [3] = '{9, 13, 4};
    int exp_s [3] = '{9, 9, 3};
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 0, cards[i], 1'b0);
      n_tests++;
      if (sc(0) !== exp_s[i] || ct(0) !== i + 1) begin
        n_fail++;
        $display("FAIL plan_hand0_card%0d: score0=%0d count0=%0d, want %0d %0d", i, sc(0), ct(0), exp_s[i], i + 1);
      end
    end
    n_tests++;
    if (full[0] !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL plan_hand0_full: full0=%b err=%b, want 1 0", full[0], err);
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b1, 1, 7, 1'b0);
    apply(1'b1, 1, 8, 1'b0);
    n_tests++;
    if (sc(1) !== 5 || ct(1) !== 2 || sc(0) !== 3) begin
      n_fail++;
      $display("FAIL back_to_back: score1=%0d count1=%0d score0=%0d, want 5 2 3", sc(1), ct(1), sc(0));
    end
  endtask

  task automatic test_full_reject();
    apply(1'b1, 0, 5, 1'b0);
    n_tests++;
    if (obs_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: load_ready=%b, want 0", obs_ready);
    end
    n_tests++;
    if (sc(0) !== 3 || ct(0) !== 3 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reject: score0=%0d count0=%0d err=%b, want 3 3 1", sc(0), ct(0), err);
    end
  endtask

  task automatic test_clear_priority();
    apply(1'b1, 1, 6, 1'b1);
    n_tests++;
    if (obs_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ready: load_ready=%b, want 0", obs_ready);
    end
    n_tests++;
    if (score !== '0 || count !== '0 || full !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_priority: score=%h count=%h full=%b err=%b, want all 0", score, count, full, err);
    end
  endtask

  task automatic test_illegal_and_async_reset();
    apply(1'b1, 0, 15, 1'b0);
    n_tests++;
    if (ct(0) !== 1 || sc(0) !== 0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_card: count0=%0d score0=%0d err=%b, want 1 0 1", ct(0), sc(0), err);
    end
    apply(1'b1, 1, 6, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (score !== '0 || count !== '0 || full !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: score=%h count=%h full=%b err=%b, want all 0", score, count, full, err);
    end
    @(negedge slow_clock);
    reset = 1'b0;
    @(posedge slow_clock);
    #1;
    model_reset();
    apply(1'b1, 1, 3, 1'b0);
    n_tests++;
    if (sc(1) !== 3 || ct(1) !== 1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_load: score1=%0d count1=%0d err=%b, want 3 1 0", sc(1), ct(1), err);
    end
  endtask

`ifdef NATURAL_DETECT_EN
  task automatic test_natural();
    apply(1'b0, 0, 0, 1'b1);
    apply(1'b1, 0, 4, 1'b0);
    n_tests++;
    if (natural[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL natural_card1: natural0=%b, want 0", natural[0]);
    end
    apply(1'b1, 0, 5, 1'b0);
    n_tests++;
    if (natural[0] !== 1'b1 || sc(0) !== 9) begin
      n_fail++;
      $display("FAIL natural_card2: natural0=%b score0=%0d, want 1 9", natural[0], sc(0));
    end
    apply(1'b1, 0, 2, 1'b0);
    n_tests++;
    if (natural[0] !== 1'b1 || sc(0) !== 1) begin
      n_fail++;
      $display("FAIL natural_hold0: natural0=%b score0=%0d, want 1 1", natural[0], sc(0));
    end
    apply(1'b1, 1, 9, 1'b0);
    apply(1'b1, 1, 10, 1'b0);
    n_tests++;
    if (natural[1] !== 1'b1 || sc(1) !== 9) begin
      n_fail++;
      $display("FAIL natural_hand1: natural1=%b score1=%0d, want 1 9", natural[1], sc(1));
    end
    apply(1'b1, 1, 8, 1'b0);
    n_tests++;
    if (natural[1] !== 1'b1 || sc(1) !== 7) begin
      n_fail++;
      $display("FAIL natural_hold1: natural1=%b score1=%0d, want 1 7", natural[1], sc(1));
    end
  endtask
`endif

  task automatic test_random();
    int h, c;
    logic v, clr;
    apply(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 24) == 0);
      h   = $urandom_range(0, NH - 1);
      c   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 13);
      apply(v, h, c, clr);
      n_tests++;
      if (obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rand_ready@%0d: load_ready=%b, want %b", i, obs_ready, exp_ready);
      end
      for (int k = 0; k < NH; k++) begin
        n_tests++;
        if (sc(k) !== m_sum[k] % 10 || ct(k) !== m_cnt[k] || full[k] !== (m_cnt[k] == MAX)) begin
          n_fail++;
          $display("FAIL rand_hand%0d@%0d: score=%0d count=%0d full=%b, want %0d %0d %0d",
                   k, i, sc(k), ct(k), full[k], m_sum[k] % 10, m_cnt[k], m_cnt[k] == MAX);
        end
`ifdef NATURAL_DETECT_EN
        n_tests++;
        if (natural[k] !== 1'(m_nat[k])) begin
          n_fail++;
          $display("FAIL rand_natural%0d@%0d: natural=%b, want %0d", k, i, natural[k], m_nat[k]);
        end
`endif
      end
      n_tests++;
      if (err !== 1'(m_err)) begin
        n_fail++;
        $display("FAIL rand_err@%0d: err=%b, want %0d", i, err, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plan_hand0();
    test_back_to_back();
    test_full_reject();
    test_clear_priority();
    test_illegal_and_async_reset();
`ifdef NATURAL_DETECT_EN
    test_natural();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
